// File: rtl/clk_enable_monitor.sv
// clk_enable_monitor
//   Receive-side checker for a periodic single-cycle enable pulse. It measures
//   the number of clock_5 cycles between pulses, declares lock after a run of
//   in-tolerance periods, and raises sticky flags for short or missing pulses.
//
// Ports
//   clock_5      in   1  system clock, rising edge
//   reset        in   1  synchronous, active-low
//   enable_in    in   1  pulse under test; each cycle sampled high is a tick
//   clear_err    in   1  clears the sticky error flags
//   period_out   out 32  last measured period in cycles
//   period_valid out  1  one-cycle strobe when period_out updates
//   tick_count   out 16  ticks since reset, wraps
//   locked       out  1  high while in LOCKED
//   err_short    out  1  sticky: a period below the lower tolerance bound was seen
//   err_long     out  1  sticky: no tick arrived within the upper tolerance bound
//   state_out    out  2  IDLE=00, MEASURE=01, LOCKED=10, LOST=11
module clk_enable_monitor #(
  parameter logic [31:0] EXPECTED_PERIOD = 32'd10000001,
  parameter logic [31:0] TOLERANCE       = 32'd0,
  parameter logic [3:0]  LOCK_COUNT      = 4'd4
) (
  input  logic        clock_5,
  input  logic        reset,
  input  logic        enable_in,
  input  logic        clear_err,
  output logic [31:0] period_out,
  output logic        period_valid,
  output logic [15:0] tick_count,
  output logic        locked,
  output logic        err_short,
  output logic        err_long,
  output logic [1:0]  state_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MEASURE   = 2'b01,
    LOCKED_ST = 2'b10,
    LOST      = 2'b11
  } state_t;

  localparam logic [31:0] PERIOD_MIN  = EXPECTED_PERIOD - TOLERANCE;
  // cnt holds (cycles since last tick - 1), so this value on a quiet cycle
  // means the upper bound has been reached without a tick.
  localparam logic [31:0] TIMEOUT_CNT = EXPECTED_PERIOD + TOLERANCE - 32'd1;

  state_t      state_q;
  logic [31:0] cnt_q;
  logic [3:0]  good_q;
  logic [31:0] period_q;
  logic        period_valid_q;
  logic [15:0] tick_count_q;
  logic        locked_q;
  logic        err_short_q;
  logic        err_long_q;

  logic        active;
  logic [31:0] period_d;
  logic        is_short;
  logic        is_timeout;
  logic        set_short;
  logic        set_long;
  logic        err_short_d;
  logic        err_long_d;

  assign active     = (state_q == MEASURE) || (state_q == LOCKED_ST);
  assign period_d   = cnt_q + 32'd1;
  assign is_short   = period_d < PERIOD_MIN;
  assign is_timeout = cnt_q == TIMEOUT_CNT;
  assign set_short  = active && enable_in && is_short;
  assign set_long   = active && !enable_in && is_timeout;

  // A new error in the same cycle as clear_err wins over the clear.
  assign err_short_d = set_short | (err_short_q & ~clear_err);
  assign err_long_d  = set_long  | (err_long_q  & ~clear_err);

  always_ff @(posedge clock_5) begin
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= 32'd0;
      good_q         <= 4'd0;
      period_q       <= 32'd0;
      period_valid_q <= 1'b0;
      tick_count_q   <= 16'd0;
      locked_q       <= 1'b0;
      err_short_q    <= 1'b0;
      err_long_q     <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      err_short_q    <= err_short_d;
      err_long_q     <= err_long_d;
      if (enable_in) begin
        tick_count_q <= tick_count_q + 16'd1;
      end

      case (state_q)
        // The interval since the previous tick is unknown here, so the
        // first tick only starts a measurement.
        IDLE, LOST: begin
          if (enable_in) begin
            state_q <= MEASURE;
            cnt_q   <= 32'd0;
          end
        end

        MEASURE: begin
          if (enable_in) begin
            cnt_q          <= 32'd0;
            period_q       <= period_d;
            period_valid_q <= 1'b1;
            if (is_short) begin
              good_q <= 4'd0;
            end else begin
              good_q <= good_q + 4'd1;
              if (good_q + 4'd1 == LOCK_COUNT) begin
                state_q  <= LOCKED_ST;
                locked_q <= 1'b1;
              end
            end
          end else if (is_timeout) begin
            state_q  <= LOST;
            good_q   <= 4'd0;
            locked_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        LOCKED_ST: begin
          if (enable_in) begin
            cnt_q          <= 32'd0;
            period_q       <= period_d;
            period_valid_q <= 1'b1;
            if (is_short) begin
              state_q  <= MEASURE;
              good_q   <= 4'd0;
              locked_q <= 1'b0;
            end
          end else if (is_timeout) begin
            state_q  <= LOST;
            good_q   <= 4'd0;
            locked_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign period_out   = period_q;
  assign period_valid = period_valid_q;
  assign tick_count   = tick_count_q;
  assign locked       = locked_q;
  assign err_short    = err_short_q;
  assign err_long     = err_long_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_clk_enable_monitor.sv
module tb_clk_enable_monitor;

  localparam int EP  = 10;
  localparam int TOL = 1;
  localparam int LC  = 3;

  localparam int P_IDLE = 0;
  localparam int P_MEAS = 1;
  localparam int P_LOCK = 2;
  localparam int P_LOST = 3;

  logic        clock_5 = 1'b0;
  logic        reset = 1'b0;
  logic        enable_in = 1'b0;
  logic        clear_err = 1'b0;
  logic [31:0] period_out;
  logic        period_valid;
  logic [15:0] tick_count;
  logic        locked;
  logic        err_short;
  logic        err_long;
  logic [1:0]  state_out;

  clk_enable_monitor #(
    .EXPECTED_PERIOD(32'd10),
    .TOLERANCE      (32'd1),
    .LOCK_COUNT     (4'd3)
  ) dut (
    .clock_5     (clock_5),
    .reset       (reset),
    .enable_in   (enable_in),
    .clear_err   (clear_err),
    .period_out  (period_out),
    .period_valid(period_valid),
    .tick_count  (tick_count),
    .locked      (locked),
    .err_short   (err_short),
    .err_long    (err_long),
    .state_out   (state_out)
  );

  always #5 clock_5 = ~clock_5;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: tracks absolute cycle numbers of ticks rather than a counter.
  int cyc      = 0;
  int last     = 0;
  int good     = 0;
  int phase    = P_IDLE;
  int m_period = 0;
  int m_ticks  = 0;
  bit m_valid  = 1'b0;
  bit m_es     = 1'b0;
  bit m_el     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input bit r, input bit e, input bit c);
    int  elapsed;
    bit  ss;
    bit  sl;
    cyc++;
    if (!r) begin
      phase = P_IDLE; good = 0; m_period = 0; m_valid = 0;
      m_ticks = 0; m_es = 0; m_el = 0;
    end else begin
      ss = 0; sl = 0; m_valid = 0;
      if (phase == P_IDLE || phase == P_LOST) begin
        if (e) begin phase = P_MEAS; last = cyc; end
      end else begin
        elapsed = cyc - last;
        if (e) begin
          last = cyc; m_period = elapsed; m_valid = 1;
          if (elapsed < EP - TOL) begin
            ss = 1; good = 0; phase = P_MEAS;
          end else if (phase == P_MEAS) begin
            good++;
            if (good == LC) phase = P_LOCK;
          end
        end else if (elapsed == EP + TOL) begin
          sl = 1; good = 0; phase = P_LOST;
        end
      end
      if (e) m_ticks = (m_ticks + 1) % 65536;
      m_es = ss | (m_es & !c);
      m_el = sl | (m_el & !c);
    end
  endtask

  // One clock: drive inputs, clock, then compare every output with the model.
  task automatic step(input bit r, input bit e, input bit c);
    reset = r; enable_in = e; clear_err = c;
    @(posedge clock_5);
    #1;
    model_step(r, e, c);
    chk("period_out",   period_out,   32'(m_period));
    chk("period_valid", period_valid, 32'(m_valid));
    chk("tick_count",   tick_count,   32'(m_ticks));
    chk("locked",       locked,       32'(phase == P_LOCK));
    chk("err_short",    err_short,    32'(m_es));
    chk("err_long",     err_long,     32'(m_el));
    chk("state_out",    state_out,    32'(phase));
    $display("cyc %0d rst=%0b en=%0b clr=%0b -> st=%0d per=%0d v=%0b ticks=%0d lk=%0b es=%0b el=%0b",
             cyc, r, e, c, state_out, period_out, period_valid, tick_count, locked, err_short, err_long);
  endtask

  // n-1 quiet cycles followed by a tick, i.e. a period of n.
  task automatic gap(input int n, input bit clr_on_tick);
    for (int i = 1; i < n; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, clr_on_tick);
  endtask

  initial begin
    // 1. reset, then 5 ticks every 10 cycles
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk("rst_state", state_out, 32'd0);
    chk("rst_ticks", tick_count, 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk("t1_no_valid", period_valid, 32'd0);
    for (int i = 0; i < 4; i++) begin
      gap(10, 1'b0);
      chk("t_valid", period_valid, 32'd1);
      chk("t_period10", period_out, 32'd10);
    end
    chk("s1_locked", locked, 32'd1);
    chk("s1_state", state_out, 32'd2);
    chk("s1_ticks", tick_count, 32'd5);
    chk("s1_errs", {err_short, err_long}, 32'd0);

    // 2. short period while locked
    gap(7, 1'b0);
    chk("s2_period", period_out, 32'd7);
    chk("s2_err_short", err_short, 32'd1);
    chk("s2_state", state_out, 32'd1);
    chk("s2_ticks", tick_count, 32'd6);

    // 3. tolerance edges
    gap(9, 1'b0);
    gap(11, 1'b0);
    gap(9, 1'b0);
    chk("s3_locked", locked, 32'd1);
    chk("s3_err_long", err_long, 32'd0);

    // 4. missing pulse
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0);
    chk("s4_err_long", err_long, 32'd1);
    chk("s4_state", state_out, 32'd3);
    chk("s4_unlocked", locked, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("s4_relock_state", state_out, 32'd1);
    chk("s4_relock_novalid", period_valid, 32'd0);
    gap(10, 1'b0);
    chk("s4_valid", period_valid, 32'd1);
    chk("s4_period", period_out, 32'd10);

    // 5. clear_err racing a new short error, then clear alone
    gap(6, 1'b1);
    chk("s5_set_wins", err_short, 32'd1);
    step(1'b1, 1'b0, 1'b1);
    chk("s5_clr_short", err_short, 32'd0);
    chk("s5_clr_long", err_long, 32'd0);
    chk("s5_state", state_out, 32'd1);

    // 6. reset mid-lock, then enable held high 3 cycles
    for (int i = 0; i < 3; i++) gap(10, 1'b0);
    chk("s6_pre_locked", locked, 32'd1);
    step(1'b0, 1'b0, 1'b0);
    chk("s6_rst_state", state_out, 32'd0);
    chk("s6_rst_period", period_out, 32'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0);
    chk("s6_period1", period_out, 32'd1);
    chk("s6_err_short", err_short, 32'd1);
    chk("s6_ticks", tick_count, 32'd3);

    // Randomized periods around nominal, random clears and occasional resets.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 39) == 0) begin
        step(1'b0, 1'b0, 1'b0);
      end else begin
        int n;
        n = $urandom_range(1, 14);
        for (int i = 1; i < n; i++) step(1'b1, 1'b0, ($urandom_range(0, 15) == 0));
        step(1'b1, 1'b1, ($urandom_range(0, 7) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_enable_monitor.md
Name: clk_enable_monitor

Overview:
Receive-side checker for the periodic single-cycle enable pulse produced by the clock-enable divider.
- Measures the interval between enable pulses in clock_5 cycles.
- Declares lock after a run of in-tolerance periods; flags short and missing pulses with sticky errors.
- Counts total ticks.
- Sits beside any logic that consumes the divided enable. Drives board LEDs/debug and gates downstream logic on `locked`.

Parameters:
EXPECTED_PERIOD, 32'd10000001, nominal clock_5 cycles between two enable pulses; must be >= 2.
TOLERANCE, 32'd0, allowed +/- deviation in cycles; must be < EXPECTED_PERIOD - 1.
LOCK_COUNT, 4'd4, consecutive good periods required to enter LOCKED; 1..15.

Ports:
clock_5  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-low.
enable_in  input  1  enable pulse under test; every cycle sampled high is one tick.
clear_err  input  1  synchronous pulse; clears sticky error flags.
period_out  output  32  last measured period in cycles.
period_valid  output  1  one-cycle strobe when period_out updates.
tick_count  output  16  ticks seen since reset; wraps 16'hFFFF -> 0.
locked  output  1  high while state is LOCKED.
err_short  output  1  sticky: a period < EXPECTED_PERIOD - TOLERANCE was seen.
err_long  output  1  sticky: no tick within EXPECTED_PERIOD + TOLERANCE cycles.
state_out  output  2  current state: IDLE=00, MEASURE=01, LOCKED=10, LOST=11.

Behaviour:
- Reset:
  - reset==0 at a clock edge takes priority over all other inputs.
  - Next cycle: state IDLE; cycle counter 0; good-period counter 0.
  - All outputs 0: period_out, period_valid, tick_count, locked, err_short, err_long, state_out.
  - Applies identically mid-operation.
- Registered outputs: every output updates on the edge following the causing input cycle (latency 1).
- Cycle counter `cnt` (32 bit):
  - Cleared to 0 on every tick cycle.
  - Otherwise increments in MEASURE and LOCKED.
  - Held in IDLE and LOST.
- Period definition: ticks at cycle 0 and cycle N give period N, computed as cnt+1 at the second tick.
- Good period: EXPECTED_PERIOD - TOLERANCE <= N <= EXPECTED_PERIOD + TOLERANCE.
- Timeout: in MEASURE or LOCKED, a non-tick cycle with cnt == EXPECTED_PERIOD + TOLERANCE - 1.
  - Sets err_long, clears locked, zeroes the good counter, goes to LOST.
  - Produces no period_valid.
- IDLE: first tick -> MEASURE; cnt cleared; no period_valid.
- MEASURE, on tick:
  - period_out <= N; period_valid pulses.
  - Good period: good counter +1. If it reaches LOCK_COUNT -> LOCKED, locked=1 on that edge.
  - Short period: err_short set, good counter 0, stay MEASURE.
- LOCKED, on tick:
  - Good period: stay LOCKED; period_valid pulses.
  - Short period: err_short set, locked 0, good counter 0, -> MEASURE.
- LOST: next tick -> MEASURE; cnt cleared; no period_valid (interval unknown).
- tick_count increments on every tick in every state.
- Enable held high k cycles: each cycle is a tick, so back-to-back ticks measure period 1 (short).
- clear_err:
  - Clears err_short and err_long next cycle.
  - If a new error condition occurs in the same cycle, set wins and the flag stays 1.
  - Has no effect on state, locked or counters.
- Long period never reported via period_out: timeout fires first.
- cnt cannot overflow, because the timeout bounds it.

Test Plan:
Use EXPECTED_PERIOD=10, TOLERANCE=1, LOCK_COUNT=3 throughout.
1. Reset low 3 cycles, then 5 ticks every 10 cycles:
   - No period_valid at tick 1.
   - period_valid with period_out=10 at ticks 2-5.
   - locked=1 and state_out=10 one cycle after tick 4.
   - tick_count=5; both error flags 0.
2. From LOCKED, next tick after 7 cycles -> period_out=7, err_short=1, locked=0, state_out=01; tick_count +1.
3. Tolerance edges: periods 9, 11, 9 from MEASURE -> all accepted, LOCKED after the third; no errors.
4. From LOCKED, stop ticks:
   - No tick at cycle 11 after the last tick -> err_long=1, state_out=11, locked=0, no period_valid.
   - Next tick -> state_out=01, no period_valid.
   - Tick 10 cycles later -> period_valid with period_out=10.
5. clear_err asserted in the same cycle as a short tick -> err_short remains 1. clear_err alone next cycle -> err_short=0, err_long=0, state unchanged.
6. Mid-LOCKED, reset low 1 cycle -> next cycle all outputs 0, state_out=00. enable_in held high 3 cycles afterwards -> MEASURE, then period_out=1 twice, err_short=1, tick_count=3.
